// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM states,
// abort-counter ceiling and the round-robin search function.
package serial_tx_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

  localparam logic [7:0] ABORT_MAX = 8'hFF;
  localparam int         MAX_REQ   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid scanning ptr+1, ptr+2, ... modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int                 nreq);
    pick_t      p;
    int         cand;
    logic [2:0] cidx;
    p = '0;
    // Walk from the farthest candidate down so the nearest one wins.
    for (int k = MAX_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % nreq;
      cidx = 3'(cand);
      if (k <= nreq && valid[cidx]) begin
        p.found = 1'b1;
        p.idx   = cidx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester byte streams plus the UART TX handshake, bundled for the arbiter.
interface serial_tx_arbiter_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              txBusy;
  logic              txStart;
  logic [7:0]        txData;

  // slave: the arbiter; master: requesters together with the UART core.
  modport slave (
    input  req_valid, req_data, req_last, txBusy,
    output req_ready, txStart, txData
  );

  modport master (
    output req_valid, req_data, req_last, txBusy,
    input  req_ready, txStart, txData
  );

endinterface

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin select: next valid requester after rr pointer.
module rr_picker
  import serial_tx_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [2:0]      ptr,
  output logic            found,
  output logic [2:0]      idx
);

  logic [MAX_REQ-1:0] valid_x;
  pick_t              pick;

  always_comb begin
    valid_x             = '0;
    valid_x[NREQ-1:0]   = valid;
    pick                = rr_pick(valid_x, ptr, NREQ);
  end

  assign found = pick.found;
  assign idx   = pick.idx;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-atomic round-robin sharing of one UART transmitter between NREQ
// byte-stream requesters, with a stall timeout that abandons a stuck packet.
module serial_tx_arbiter
  import serial_tx_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  serial_tx_arbiter_if.slave  bus,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic [7:0]          abort_cnt
);

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [15:0]        stall_cnt;
  logic               last_q;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [MAX_REQ-1:0] valid_x;
  logic [MAX_REQ-1:0] last_x;
  logic [7:0]         data_x [MAX_REQ];
  logic [NREQ-1:0]    ready_oh;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pad requester lanes to MAX_REQ so grant_id can index them directly.
  always_comb begin
    valid_x = '0;
    last_x  = '0;
    for (int i = 0; i < MAX_REQ; i++) data_x[i] = '0;
    for (int i = 0; i < NREQ; i++) begin
      valid_x[i] = bus.req_valid[i];
      last_x[i]  = bus.req_last[i];
      data_x[i]  = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    ready_oh = '0;
    for (int i = 0; i < NREQ; i++) ready_oh[i] = (grant_id == 3'(i));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.txStart   <= 1'b0;
      bus.txData    <= '0;
      bus.req_ready <= '0;
      grant_id      <= '0;
      abort_cnt     <= '0;
      rr_ptr        <= 3'(NREQ-1);
      stall_cnt     <= '0;
      last_q        <= 1'b0;
    end else begin
      bus.txStart   <= 1'b0;
      bus.req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            stall_cnt <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // A busy UART with a byte waiting is back-pressure, not a stall.
          if (valid_x[grant_id]) begin
            if (!bus.txBusy) begin
              bus.txData    <= data_x[grant_id];
              bus.txStart   <= 1'b1;
              bus.req_ready <= ready_oh;
              last_q        <= last_x[grant_id];
              stall_cnt     <= '0;
              state         <= GAP;
            end
          end else if (stall_cnt == 16'(TIMEOUT-1)) begin
            if (abort_cnt != ABORT_MAX) abort_cnt <= abort_cnt + 8'd1;
            rr_ptr <= grant_id;
            state  <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        GAP: begin
          if (last_q) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: randomized packet rounds checked
// against a packet-level round-robin model, plus timeout and reset scenarios.
module tb_serial_tx_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } item_t;

  typedef struct {
    int         r;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] grant_id;
  logic       busy;
  logic [7:0] abort_cnt;

  serial_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  serial_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort_cnt (abort_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  exp_t       sb[$];
  item_t      drv_q [NREQ][$];
  bit         presenting [NREQ];
  bit         armed [NREQ];
  int         gap_left [NREQ];
  int         start_cyc[$];
  int         busy_mode = 0;
  int         busy_left = 0;
  logic [7:0] held = '0;
  logic [7:0] stage[$];
  int         model_last;
  int         model_abort;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Requester drivers: present queued bytes, advance on req_ready.
  initial begin
    item_t tmp;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (presenting[i] && bus.req_ready[i]) begin
          tmp = drv_q[i].pop_front();
          presenting[i] = 1'b0;
        end
        if (!presenting[i] && drv_q[i].size() > 0) begin
          if (!armed[i]) begin
            gap_left[i] = drv_q[i][0].gap;
            armed[i] = 1'b1;
          end
          if (gap_left[i] > 0) gap_left[i]--;
          else begin
            presenting[i] = 1'b1;
            armed[i] = 1'b0;
          end
        end
        bus.req_valid[i] = presenting[i];
        if (presenting[i]) begin
          bus.req_data[8*i +: 8] = drv_q[i][0].d;
          bus.req_last[i] = drv_q[i][0].l;
        end
      end
    end
  end

  // UART model: raises txBusy for a mode-dependent time after each start.
  initial begin
    bus.txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.txStart)
        busy_left = (busy_mode == 1) ? 10 : (busy_mode == 2) ? int'($urandom_range(0, 4)) : 0;
      if (busy_left > 0) begin
        bus.txBusy = 1'b1;
        busy_left--;
      end else begin
        bus.txBusy = 1'b0;
      end
    end
  end

  // Monitor: every start must match the scoreboard head; otherwise outputs hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = '0;
      end else if (bus.txStart) begin
        start_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: actual data=%0h grant=%0d, required no transfer", bus.txData, grant_id);
        end else begin
          e = sb.pop_front();
          chk("txData", 32'(bus.txData), 32'(e.d));
          chk("grant_id", 32'(grant_id), e.r);
          chk("req_ready_pulse", 32'(bus.req_ready), 32'(1) << e.r);
        end
        held = bus.txData;
      end else begin
        chk("txData_hold", 32'(bus.txData), 32'(held));
        chk("req_ready_quiet", 32'(bus.req_ready), 0);
      end
    end
  end

  task automatic send_pkt(input int r, input bit with_last, input int maxgap);
    item_t it;
    exp_t  e;
    for (int k = 0; k < stage.size(); k++) begin
      it.d   = stage[k];
      it.l   = with_last && (k == stage.size() - 1);
      it.gap = (k == 0) ? 0 : int'($urandom_range(0, maxgap));
      drv_q[r].push_back(it);
      e.r = r;
      e.d = stage[k];
      sb.push_back(e);
    end
    stage.delete();
  endtask

  // Model: all masked requesters present together; serve in rr order from last grant.
  task automatic round(input logic [NREQ-1:0] mask, input int maxlen, input int maxgap, input bit fixed);
    int base;
    int j;
    int len;
    base = model_last;
    for (int k = 1; k <= NREQ; k++) begin
      j = (base + k) % NREQ;
      if (mask[j]) begin
        if (fixed) stage.push_back(8'hAA + 8'(j * 17));
        else begin
          len = int'($urandom_range(1, maxlen));
          repeat (len) stage.push_back(8'($urandom));
        end
        send_pkt(j, 1'b1, maxgap);
        model_last = j;
      end
    end
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      presenting[i] = 1'b0;
      armed[i] = 1'b0;
    end
    bus.req_valid = '0;
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = !busy && (sb.size() == 0);
    for (int i = 0; i < NREQ; i++)
      if (drv_q[i].size() != 0 || presenting[i]) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (all_idle()) break;
      n++;
      if (n > budget) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: actual=busy after %0d cycles required=idle", nm, budget);
        flush();
        break;
      end
    end
  endtask

  initial begin
    int t0;
    logic [NREQ-1:0] mask;
    model_last  = NREQ - 1;
    model_abort = 0;

    repeat (3) @(negedge clk);
    chk("rst_txStart", 32'(bus.txStart), 0);
    chk("rst_txData", 32'(bus.txData), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort_cnt", 32'(abort_cnt), 0);
    reset = 1'b0;

    // Simultaneous single-byte requests, twice: 0,1,0,1.
    @(negedge clk);
    #1;
    round(3'b011, 1, 0, 1'b1);
    wait_done("t2a", 100);
    chk("t2a_grant", 32'(grant_id), 1);
    round(3'b011, 1, 0, 1'b1);
    wait_done("t2b", 100);
    chk("t2b_grant", 32'(grant_id), 1);

    // Three-byte packet, idle UART: 2-cycle latency and spacing.
    start_cyc.delete();
    t0 = cyc;
    stage.push_back(8'h08);
    stage.push_back(8'h01);
    stage.push_back(8'h02);
    send_pkt(0, 1'b1, 0);
    model_last = 0;
    wait_done("t1", 100);
    chk("t1_starts", start_cyc.size(), 3);
    if (start_cyc.size() > 0) chk("t1_latency", start_cyc[0] - (t0 + 1), 2);
    for (int i = 0; i + 1 < start_cyc.size(); i++)
      chk("t1_spacing", start_cyc[i+1] - start_cyc[i], 2);
    chk("t1_busy", 32'(busy), 0);

    // UART busy 10 cycles after each start: bytes wait for it.
    busy_mode = 1;
    start_cyc.delete();
    stage.push_back(8'h11);
    stage.push_back(8'h22);
    stage.push_back(8'h33);
    send_pkt(2, 1'b1, 0);
    model_last = 2;
    wait_done("t3", 200);
    chk("t3_starts", start_cyc.size(), 3);
    for (int i = 0; i + 1 < start_cyc.size(); i++)
      chk("t3_spacing", start_cyc[i+1] - start_cyc[i], 11);
    busy_mode = 0;

    // req1 stalls mid-packet; req0 waits and wins after the abort.
    start_cyc.delete();
    stage.push_back(8'h3C);
    send_pkt(1, 1'b0, 0);
    begin
      int n;
      n = 0;
      while (drv_q[1].size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t4_req1_consumed", drv_q[1].size(), 0);
    end
    #1;
    stage.push_back(8'h5A);
    send_pkt(0, 1'b1, 0);
    model_abort++;
    model_last = 0;
    wait_done("t4", 100);
    chk("t4_starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) chk("t4_abort_delay", start_cyc[1] - start_cyc[0], TIMEOUT + 3);
    chk("t4_abort_cnt", 32'(abort_cnt), model_abort);
    chk("t4_grant", 32'(grant_id), 0);

    // Reset in the GAP of a 4-byte packet.
    round(3'b010, 1, 0, 1'b1);
    wait_done("t5a", 100);
    for (int k = 0; k < 4; k++) stage.push_back(8'hC0 + 8'(k));
    send_pkt(2, 1'b1, 0);
    begin
      int n;
      n = 0;
      forever begin
        @(negedge clk);
        #1;
        if (bus.txStart && sb.size() == 2) break;
        n++;
        if (n > 100) begin
          total++;
          bad++;
          $display("FAIL t5_wait: actual=second byte not seen required=seen");
          break;
        end
      end
    end
    #1;
    reset = 1'b1;
    #1;
    chk("t5_txStart", 32'(bus.txStart), 0);
    chk("t5_txData", 32'(bus.txData), 0);
    chk("t5_req_ready", 32'(bus.req_ready), 0);
    chk("t5_grant_id", 32'(grant_id), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_abort_cnt", 32'(abort_cnt), 0);
    flush();
    model_last  = NREQ - 1;
    model_abort = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    round(3'b111, 1, 0, 1'b1);
    wait_done("t5b", 100);
    chk("t5b_grant", 32'(grant_id), model_last);
    chk("t5b_abort_cnt", 32'(abort_cnt), 0);

    // Randomized rounds with stalls and random UART busy time.
    busy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      round(mask, 4, 5, 1'b0);
      wait_done("rand", 400);
      chk("rand_grant", 32'(grant_id), model_last);
      chk("rand_abort_cnt", 32'(abort_cnt), model_abort);
    end
    busy_mode = 0;

    // 260 aborts: counter saturates and never wraps.
    for (int n = 0; n < 260; n++) begin
      stage.push_back(8'(n));
      send_pkt(n % NREQ, 1'b0, 0);
      model_last  = n % NREQ;
      model_abort = (model_abort < 255) ? model_abort + 1 : 255;
      wait_done("sat", 100);
      chk("sat_abort_cnt", 32'(abort_cnt), model_abort);
    end
    chk("sat_final", 32'(abort_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
